// File: rtl/swt16_pkg.sv
// Shared fetch definitions: FSM state encoding and default geometry of the
// program counter / program memory word.
package swt16_pkg;

  localparam int PC_WIDTH_DEF        = 12;
  localparam int PMEM_WORD_WIDTH_DEF = 16;
  localparam int RESET_PC_DEF        = 0;
  localparam int PERF_CNT_W          = 16;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer holding the instruction word and its PC while the
// decoder stalls.
module fetch_hold_buf #(
  parameter int PC_WIDTH   = 12,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  invalidate,
  input  logic [WORD_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  held_valid,
  output logic [WORD_WIDTH-1:0] held_instr,
  output logic [PC_WIDTH-1:0]   held_pc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
    end else if (invalidate) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid <= 1'b1;
    end
  end

  // Payload is only observed while held_valid is set, so it needs no reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      held_instr <= instr;
      held_pc    <= pc;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues PMEM addresses, presents words to the decoder,
// handles stalls and redirects. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch
  import swt16_pkg::*;
#(
  parameter int PC_WIDTH        = PC_WIDTH_DEF,
  parameter int PMEM_WORD_WIDTH = PMEM_WORD_WIDTH_DEF,
  parameter int RESET_PC        = RESET_PC_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_stall,
  input  logic                       in_jump,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
  output logic [PC_WIDTH-1:0]        out_pmem_addr,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_valid,
  output logic                       out_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]      out_fetch_cnt,
  output logic [PERF_CNT_W-1:0]      out_flush_cnt
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  fetch_state_e               state, state_nxt;
  logic [PC_WIDTH-1:0]        pc, pc_nxt;
  logic [PC_WIDTH-1:0]        pc_d1, pc_d1_nxt;
  logic                       capture, invalidate;
  logic                       held_valid;
  logic [PMEM_WORD_WIDTH-1:0] held_instr;
  logic [PC_WIDTH-1:0]        held_pc;

  fetch_hold_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .WORD_WIDTH (PMEM_WORD_WIDTH)
  ) u_hold_buf (
    .clock      (clock),
    .reset      (reset),
    .capture    (capture),
    .invalidate (invalidate),
    .instr      (in_pmem_data),
    .pc         (pc_d1),
    .held_valid (held_valid),
    .held_instr (held_instr),
    .held_pc    (held_pc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_FILL;
      pc    <= PC_RST;
      pc_d1 <= PC_RST;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pc_d1 <= pc_d1_nxt;
    end
  end

  assign out_pmem_addr = pc;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    pc_d1_nxt  = pc_d1;
    capture    = 1'b0;
    invalidate = 1'b0;
    out_instr  = '0;
    out_pc     = pc_d1;
    out_valid  = 1'b0;
    out_flush  = 1'b0;

    case (state)
      ST_FILL: begin
        pc_nxt    = pc + PC_ONE;
        pc_d1_nxt = pc;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        out_instr = in_pmem_data;
        out_valid = 1'b1;
        if (in_stall) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          pc_nxt    = pc + PC_ONE;
          pc_d1_nxt = pc;
        end
      end
      // pc was re-issued throughout HOLD, so PMEM already returns the next word.
      ST_HOLD: begin
        out_instr = held_instr;
        out_pc    = held_pc;
        out_valid = held_valid;
        if (!in_stall) begin
          invalidate = 1'b1;
          pc_nxt     = pc + PC_ONE;
          pc_d1_nxt  = pc;
          state_nxt  = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        out_flush = 1'b1;
        pc_nxt    = pc + PC_ONE;
        pc_d1_nxt = pc;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_FILL;
    endcase

    // A redirect overrides everything, including a pending stall.
    if (in_jump) begin
      pc_nxt     = in_jump_target;
      pc_d1_nxt  = pc;
      capture    = 1'b0;
      invalidate = 1'b1;
      out_valid  = 1'b0;
      state_nxt  = ST_REDIRECT;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == {PERF_CNT_W{1'b1}}) ? v : v + PERF_CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_fetch_cnt <= '0;
      out_flush_cnt <= '0;
    end else begin
      if (out_valid && !in_stall) out_fetch_cnt <= sat_inc(out_fetch_cnt);
      if (in_jump)                out_flush_cnt <= sat_inc(out_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: program-order stream model checked every cycle, directed
// scenarios with literal expectations, then randomized stall/jump/reset traffic.
module tb_fetch;
  import swt16_pkg::*;

  localparam int PCW = 12;
  localparam int WW  = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           in_stall = 1'b0;
  logic           in_jump = 1'b0;
  logic [PCW-1:0] in_jump_target = '0;
  logic [PCW-1:0] out_pmem_addr;
  logic [WW-1:0]  in_pmem_data = '0;
  logic [WW-1:0]  out_instr;
  logic [PCW-1:0] out_pc;
  logic           out_valid;
  logic           out_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]    out_fetch_cnt;
  logic [15:0]    out_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] mem [0:(1<<PCW)-1];

  fetch dut (
    .clock          (clock),
    .reset          (reset),
    .in_stall       (in_stall),
    .in_jump        (in_jump),
    .in_jump_target (in_jump_target),
    .out_pmem_addr  (out_pmem_addr),
    .in_pmem_data   (in_pmem_data),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_valid      (out_valid),
    .out_flush      (out_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .out_fetch_cnt  (out_fetch_cnt),
    .out_flush_cnt  (out_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous program memory
  always @(posedge clock) in_pmem_data <= mem[out_pmem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the decoder must see every PC in program order exactly
  // once per handshake, restarting at the target after each jump.
  bit             m_fill = 1'b1;
  bit             m_prev_jump = 1'b0;
  bit             m_exp_valid;
  logic [PCW-1:0] m_pc = '0;
  int             m_fetch_cnt = 0;
  int             m_flush_cnt = 0;

  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_flush", {31'b0, out_flush}, 32'd0);
      check("rst_instr", {16'b0, out_instr}, 32'd0);
      check("rst_addr", {20'b0, out_pmem_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetch_cnt", {16'b0, out_fetch_cnt}, 32'd0);
      check("rst_flush_cnt", {16'b0, out_flush_cnt}, 32'd0);
`endif
      m_fill = 1'b1;
      m_prev_jump = 1'b0;
      m_pc = '0;
      m_fetch_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      m_exp_valid = !in_jump && !m_prev_jump && !m_fill;
      check("valid", {31'b0, out_valid}, {31'b0, m_exp_valid});
      check("flush", {31'b0, out_flush}, {31'b0, m_prev_jump});
      if (m_exp_valid && out_valid) begin
        check("pc", {20'b0, out_pc}, {20'b0, m_pc});
        check("instr", {16'b0, out_instr}, {16'b0, mem[m_pc]});
      end
`ifdef FETCH_PERF_CNT_EN
      check("fetch_cnt", {16'b0, out_fetch_cnt}, m_fetch_cnt);
      check("flush_cnt", {16'b0, out_flush_cnt}, m_flush_cnt);
`endif
      if (in_jump) begin
        m_pc = in_jump_target;
        if (m_flush_cnt < 16'hFFFF) m_flush_cnt++;
      end else if (m_exp_valid && !in_stall) begin
        m_pc = m_pc + 1'b1;
        if (m_fetch_cnt < 16'hFFFF) m_fetch_cnt++;
      end
      m_prev_jump = in_jump;
      m_fill = 1'b0;
    end
  end

  task automatic step(input bit st, input bit jp, input logic [PCW-1:0] tg);
    @(negedge clock);
    in_stall = st;
    in_jump = jp;
    in_jump_target = tg;
    #2;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    in_stall = 1'b0;
    in_jump = 1'b0;
    #2;
  endtask

  initial begin
    int r;
    logic [PCW-1:0] tg;
    for (int i = 0; i < (1 << PCW); i++) mem[i] = WW'($urandom);
    mem[0] = 16'h1011;
    mem[1] = 16'h2022;
    mem[2] = 16'h3033;
    mem[3] = 16'h4044;

    repeat (3) @(negedge clock);
    release_reset();
    check("fill_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    check("run_pc0", {20'b0, out_pc}, 32'h0);
    check("run_instr0", {16'b0, out_instr}, 32'h1011);
    step(0, 0, 0);
    check("run_pc1", {20'b0, out_pc}, 32'h1);
    check("run_instr1", {16'b0, out_instr}, 32'h2022);
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 0, 0);
      check("stall_pc2", {20'b0, out_pc}, 32'h2);
      check("stall_instr2", {16'b0, out_instr}, 32'h3033);
    end
    step(0, 0, 0);
    check("after_stall_pc3", {20'b0, out_pc}, 32'h3);
    check("after_stall_instr3", {16'b0, out_instr}, 32'h4044);
    step(0, 0, 0);
    check("pc4", {20'b0, out_pc}, 32'h4);
    step(0, 1, 12'h100);
    check("jump_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    check("redirect_flush", {31'b0, out_flush}, 32'd1);
    check("redirect_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    check("target_pc", {20'b0, out_pc}, 32'h100);
    step(0, 0, 0);
    check("target_pc1", {20'b0, out_pc}, 32'h101);
    step(1, 0, 0);
    step(1, 1, 12'h200);
    check("hold_jump_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("hold_jump_pc", {20'b0, out_pc}, 32'h200);
    step(0, 1, 12'hFFF);
    step(0, 0, 0);
    step(0, 0, 0);
    check("wrap_pc_max", {20'b0, out_pc}, 32'hFFF);
    step(0, 0, 0);
    check("wrap_pc_zero", {20'b0, out_pc}, 32'h0);
    check("wrap_instr_zero", {16'b0, out_instr}, 32'h1011);
    step(0, 1, 12'h002);
    check("fallthru_jump_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    check("fallthru_flush", {31'b0, out_flush}, 32'd1);
    step(0, 0, 0);
    check("fallthru_pc", {20'b0, out_pc}, 32'h2);
    check("fallthru_instr", {16'b0, out_instr}, 32'h3033);

    // Reset arriving in the middle of a redirect
    step(0, 1, 12'h300);
    step(0, 0, 0);
    check("pre_reset_flush", {31'b0, out_flush}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_flush", {31'b0, out_flush}, 32'd0);
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_instr", {16'b0, out_instr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("async_rst_fetch_cnt", {16'b0, out_fetch_cnt}, 32'd0);
    check("async_rst_flush_cnt", {16'b0, out_flush_cnt}, 32'd0);
`endif
    repeat (2) @(negedge clock);
    release_reset();
    check("rerelease_fill_valid", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    check("rerelease_valid", {31'b0, out_valid}, 32'd1);
    check("rerelease_pc", {20'b0, out_pc}, 32'h0);

    // Randomized traffic, checked cycle by cycle by the model
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        @(negedge clock);
        reset = 1'b0;
        in_jump = 1'b0;
        in_stall = 1'b0;
        release_reset();
      end else begin
        case ($urandom_range(0, 3))
          0:       tg = out_pc + 1'b1;
          1:       tg = 12'hFFE + PCW'($urandom_range(0, 1));
          default: tg = PCW'($urandom);
        endcase
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, tg);
      end
    end

    @(negedge clock);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
